// File: rtl/pkt_framer.sv
// Transmit packet framer: preamble, type, length, payload, 32-bit sum FCS.
// Emits one byte per clock; payload starvation becomes substituted bytes.
module pkt_framer #(
  parameter int unsigned CTRL_PKT_LEN = 64,
  parameter int unsigned PRE_PAIRS    = 5,
  parameter int unsigned GAP_LEN      = 2,
  parameter logic [7:0]  IDLE_BYTE    = 8'h00,
  parameter logic [7:0]  UNDR_BYTE    = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  pkt_type,
  input  logic [15:0] pkt_len,
  input  logic [7:0]  din,
  input  logic        din_vld,
  output logic        din_rdy,
  output logic [7:0]  dout,
  output logic        dout_vld,
  output logic        dout_sop,
  output logic        dout_eop,
  output logic        busy,
  output logic        err_len,
  output logic        err_undr,
  output logic [15:0] pkt_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_TYPE, S_LEN, S_DATA, S_FCS, S_GAP
  } state_t;

  localparam logic [15:0] PRE_LAST = 16'(2 * PRE_PAIRS - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_LEN - 1);
  localparam logic [15:0] CTRL_L   = 16'(CTRL_PKT_LEN);

  state_t      state;
  logic [7:0]  typ;
  logic [15:0] len;
  logic [15:0] cnt;
  logic [31:0] sum;
  logic [7:0]  pay;

  assign din_rdy = (state == S_DATA);
  assign pay     = din_vld ? din : UNDR_BYTE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      typ      <= '0;
      len      <= '0;
      cnt      <= '0;
      sum      <= '0;
      dout     <= IDLE_BYTE;
      dout_vld <= 1'b0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
      busy     <= 1'b0;
      err_len  <= 1'b0;
      err_undr <= 1'b0;
      pkt_cnt  <= '0;
    end else begin
      dout     <= IDLE_BYTE;
      dout_vld <= 1'b0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
      err_len  <= 1'b0;
      err_undr <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (pkt_type == 8'd0 || pkt_len != 16'd0) begin
              typ   <= pkt_type;
              len   <= (pkt_type == 8'd0) ? CTRL_L : pkt_len;
              sum   <= '0;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= S_PRE;
            end else begin
              err_len <= 1'b1;
            end
          end
        end
        S_PRE: begin
          dout     <= cnt[0] ? 8'hD5 : 8'h55;
          dout_vld <= 1'b1;
          dout_sop <= (cnt == 16'd0);
          if (cnt == PRE_LAST) begin
            cnt   <= '0;
            state <= S_TYPE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_TYPE: begin
          dout     <= typ;
          dout_vld <= 1'b1;
          if (typ == 8'd0) begin
            cnt   <= len - 16'd1;
            state <= S_DATA;
          end else begin
            cnt   <= '0;
            state <= S_LEN;
          end
        end
        S_LEN: begin
          dout     <= cnt[0] ? len[7:0] : len[15:8];
          dout_vld <= 1'b1;
          if (cnt[0]) begin
            cnt   <= len - 16'd1;
            state <= S_DATA;
          end else begin
            cnt <= 16'd1;
          end
        end
        S_DATA: begin
          // starved cycles still consume a payload slot
          dout     <= pay;
          dout_vld <= 1'b1;
          err_undr <= !din_vld;
          sum      <= sum + {24'd0, pay};
          if (cnt == 16'd0) begin
            state <= S_FCS;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_FCS: begin
          dout_vld <= 1'b1;
          unique case (cnt[1:0])
            2'd0:    dout <= sum[31:24];
            2'd1:    dout <= sum[23:16];
            2'd2:    dout <= sum[15:8];
            default: dout <= sum[7:0];
          endcase
          if (cnt[1:0] == 2'd3) begin
            dout_eop <= 1'b1;
            pkt_cnt  <= pkt_cnt + 16'd1;
            cnt      <= '0;
            state    <= S_GAP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_framer.sv
// Bench for pkt_framer: vector table, directed corners, random frames
// checked against a byte-list model of the frame format.
module tb_pkt_framer;

  localparam int CTRL = 64;
  localparam int GAP  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  pkt_type = '0;
  logic [15:0] pkt_len = '0;
  logic [7:0]  din = '0;
  logic        din_vld = 1'b0;
  logic        din_rdy;
  logic [7:0]  dout;
  logic        dout_vld, dout_sop, dout_eop;
  logic        busy, err_len, err_undr;
  logic [15:0] pkt_cnt;

  pkt_framer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .pkt_type(pkt_type), .pkt_len(pkt_len),
    .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
    .dout(dout), .dout_vld(dout_vld),
    .dout_sop(dout_sop), .dout_eop(dout_eop),
    .busy(busy), .err_len(err_len), .err_undr(err_undr),
    .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cnt_exp = 0;
  logic [7:0] pay_q[$];
  bit         vld_q[$];
  logic [7:0] got_q[$];

  typedef struct {
    logic [7:0]  t;
    logic [15:0] l;
    bit          err;
    int          nbytes;
  } vec_t;

  function automatic logic [13:0] act();
    return {dout, dout_vld, dout_sop, dout_eop, err_undr, err_len, busy};
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fill(input int n, input int undr_pct);
    pay_q = {};
    vld_q = {};
    for (int i = 0; i < n; i++) begin
      pay_q.push_back(8'($urandom));
      vld_q.push_back($urandom_range(0, 99) >= undr_pct);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after
  // the last gap byte, so consecutive calls start frames back to back.
  task automatic run_frame(input logic [7:0] t, input logic [15:0] lr,
                           input bit noise);
    logic [7:0]  ex[$];
    logic [7:0]  b;
    logic [31:0] s;
    int          len, hdr, d, n;
    bit          isd, ud;
    len = (t == 8'd0) ? CTRL : int'(lr);
    ex = {};
    for (int i = 0; i < 5; i++) begin
      ex.push_back(8'h55);
      ex.push_back(8'hD5);
    end
    ex.push_back(t);
    if (t != 8'd0) begin
      ex.push_back(lr[15:8]);
      ex.push_back(lr[7:0]);
    end
    hdr = ex.size();
    s = 0;
    for (int i = 0; i < len; i++) begin
      b = vld_q[i] ? pay_q[i] : 8'h00;
      ex.push_back(b);
      s = s + 32'(b);
    end
    ex.push_back(s[31:24]);
    ex.push_back(s[23:16]);
    ex.push_back(s[15:8]);
    ex.push_back(s[7:0]);
    n = ex.size();
    got_q = {};
    d = 0;
    start = 1'b1;
    pkt_type = t;
    pkt_len = lr;
    @(negedge clk);
    start = 1'b0;
    chk("accept", 32'(act()), 32'({8'h00, 6'b000001}));
    for (int j = 0; j < n; j++) begin
      isd = (j >= hdr) && (j < hdr + len);
      chk("din_rdy", 32'(din_rdy), 32'(isd));
      ud = 1'b0;
      if (isd) begin
        din = pay_q[d];
        din_vld = vld_q[d];
        ud = !vld_q[d];
        d++;
      end else begin
        din = 8'($urandom);
        din_vld = 1'($urandom);
      end
      if (noise) begin
        start = ($urandom_range(0, 3) == 0);
        pkt_type = 8'($urandom);
        pkt_len = 16'($urandom_range(0, 2));
      end
      @(negedge clk);
      chk("byte", 32'(act()),
          32'({ex[j], 1'b1, j == 0, j == n - 1, ud, 1'b0, 1'b1}));
      if (dout_vld) got_q.push_back(dout);
    end
    start = 1'b0;
    din_vld = 1'b0;
    pkt_type = '0;
    pkt_len = '0;
    cnt_exp = (cnt_exp + 1) & 16'hFFFF;
    for (int g = 0; g < GAP; g++) begin
      @(negedge clk);
      chk("gap", 32'(act()), 32'({8'h00, 5'b0, g < GAP - 1}));
      chk("pkt_cnt", 32'(pkt_cnt), 32'(cnt_exp));
    end
  endtask

  vec_t tbl[6];
  logic [7:0] exp_d[20];
  logic [7:0] exp_tail[4];

  initial begin
    tbl[0] = '{8'h00, 16'd0,   1'b0, 79};
    tbl[1] = '{8'h00, 16'd9,   1'b0, 79};
    tbl[2] = '{8'h02, 16'd0,   1'b1, 0};
    tbl[3] = '{8'h01, 16'd1,   1'b0, 18};
    tbl[4] = '{8'h7F, 16'd256, 1'b0, 273};
    tbl[5] = '{8'hFF, 16'd2,   1'b0, 19};
    exp_d = '{8'h55, 8'hD5, 8'h55, 8'hD5, 8'h55, 8'hD5, 8'h55, 8'hD5,
              8'h55, 8'hD5, 8'h01, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC,
              8'h00, 8'h00, 8'h02, 8'h31};

    repeat (3) @(negedge clk);
    chk("reset_out", 32'(act()), 32'h0);
    chk("reset_cnt", 32'(pkt_cnt), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_rdy", 32'(din_rdy), 32'h0);

    for (int v = 0; v < 6; v++) begin
      if (tbl[v].err) begin
        start = 1'b1;
        pkt_type = tbl[v].t;
        pkt_len = tbl[v].l;
        @(negedge clk);
        start = 1'b0;
        chk("err_len_on", 32'(act()), 32'({8'h00, 6'b000010}));
        @(negedge clk);
        chk("err_len_off", 32'(act()), 32'h0);
      end else begin
        fill(tbl[v].t == 8'd0 ? CTRL : int'(tbl[v].l), 10);
        run_frame(tbl[v].t, tbl[v].l, 1'b0);
        chk("nbytes", 32'(got_q.size()), 32'(tbl[v].nbytes));
      end
    end

    pay_q = {};
    vld_q = {};
    for (int i = 0; i < CTRL; i++) begin
      pay_q.push_back(8'(i));
      vld_q.push_back(1'b1);
    end
    run_frame(8'h00, 16'd0, 1'b0);
    exp_tail = '{8'h00, 8'h00, 8'h07, 8'hE0};
    for (int i = 0; i < 4; i++)
      chk("ctrl_fcs", 32'(got_q[75 + i]), 32'(exp_tail[i]));

    pay_q = '{8'hAA, 8'hBB, 8'hCC};
    vld_q = '{1'b1, 1'b1, 1'b1};
    run_frame(8'h01, 16'd3, 1'b0);
    chk("data_size", 32'(got_q.size()), 32'd20);
    for (int i = 0; i < 20; i++)
      chk("data_byte", 32'(got_q[i]), 32'(exp_d[i]));

    pay_q = '{8'h10, 8'h20, 8'h30, 8'h40};
    vld_q = '{1'b1, 1'b0, 1'b1, 1'b1};
    run_frame(8'h01, 16'd4, 1'b0);
    exp_tail = '{8'h10, 8'h00, 8'h30, 8'h40};
    for (int i = 0; i < 4; i++)
      chk("undr_pay", 32'(got_q[13 + i]), 32'(exp_tail[i]));
    exp_tail = '{8'h00, 8'h00, 8'h00, 8'h80};
    for (int i = 0; i < 4; i++)
      chk("undr_fcs", 32'(got_q[17 + i]), 32'(exp_tail[i]));

    fill(12, 0);
    run_frame(8'h05, 16'd12, 1'b1);

    start = 1'b1;
    pkt_type = 8'h01;
    pkt_len = 16'd20;
    @(negedge clk);
    start = 1'b0;
    din_vld = 1'b1;
    repeat (18) begin
      din = 8'($urandom);
      @(negedge clk);
    end
    chk("mid_data_vld", 32'({din_rdy, dout_vld}), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out", 32'(act()), 32'h0);
    chk("rst_cnt", 32'(pkt_cnt), 32'h0);
    chk("rst_rdy", 32'(din_rdy), 32'h0);
    din_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt_exp = 0;
    @(negedge clk);
    chk("rst_quiet", 32'(act()), 32'h0);
    fill(7, 20);
    run_frame(8'h03, 16'd7, 1'b0);

    fill(CTRL, 0);
    run_frame(8'h00, 16'd0, 1'b0);
    fill(300, 0);
    run_frame(8'h01, 16'd300, 1'b0);
    chk("b2b_size", 32'(got_q.size()), 32'd317);

    for (int r = 0; r < 20; r++) begin
      logic [7:0]  t;
      logic [15:0] l;
      t = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      l = 16'($urandom_range(1, 40));
      fill(t == 8'd0 ? CTRL : int'(l), 15);
      run_frame(t, l, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
